mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//   Multi-cycle multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
//   Consumes the forwarded operands (operand B is taken after the ALUSrc/forwarding mux)
//   when EX issues mult/multu/div/divu, and owns the HI/LO registers.
//   Runs for a fixed number of cycles and asserts busy meanwhile, so the hazard unit
//   can stall later HI/LO users (mfhi/mflo/mthi/mtlo/md ops).
// PARAMETERS
//   MULT_CYCLES  5   cycles busy is high after a mult/multu start (>=1)
//   DIV_CYCLES   10  cycles busy is high after a div/divu start (>=1)
// PORTS
//   clk        in   1   system clock, rising edge
//   reset_n    in   1   asynchronous active-low reset
//   start      in   1   1-cycle pulse from EX: md instruction issued this cycle
//   op         in   2   00 mult, 01 multu, 10 div, 11 divu; sampled with start
//   operand_a  in   32  forwarded rs value; sampled with start
//   operand_b  in   32  forwarded rt value; sampled with start
//   hi_we      in   1   mthi write enable
//   lo_we      in   1   mtlo write enable
//   wdata      in   32  mthi/mtlo data
//   busy       out  1   operation in progress
//   hi         out  32  HI register
//   lo         out  32  LO register
// BEHAVIOUR
//   Reset (async, reset_n=0):
//     state=IDLE, busy=0, hi=0, lo=0, counter=0.
//     Reset mid-operation aborts it; the result is never written.
//   FSM IDLE:
//     start=1 -> latch op/operands, load counter with MULT_CYCLES or DIV_CYCLES by op[1], go BUSY.
//     Otherwise hi_we/lo_we write wdata to hi/lo at the edge.
//   FSM BUSY:
//     busy=1; counter decrements each edge.
//     At the edge where counter goes 1->0, commit the result to hi/lo and return to IDLE,
//     so busy is high for exactly N cycles.
//     Result is visible on hi/lo in the first cycle busy=0.
//   busy is registered. It rises the cycle after the start edge; the hazard unit stalls
//     on (start|busy).
//   start, hi_we and lo_we are ignored while BUSY.
//   start and hi_we/lo_we asserted together in IDLE: start wins, the write is dropped.
//   Back-to-back: start in the first IDLE cycle after completion is accepted normally.
//   Arithmetic:
//     mult: {hi,lo} = signed 32x32 -> 64-bit product.
//     multu: {hi,lo} = unsigned 32x32 -> 64-bit product.
//     div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//     divu: unsigned lo = a/b, hi = a%b.
//     Result may be computed by any method (iterative or combinational at latch time),
//       but hi/lo must not change before commit.
//   Boundary cases:
//     Divide by zero (operand_b==0, div or divu): full latency, busy behaves normally,
//       hi/lo left unchanged.
//     Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//   Unused op encodings: none; all 4 are valid.
// TESTING
//   1. Reset mid-BUSY: start multu, assert reset_n=0 on cycle 2 -> busy=0, hi=lo=0,
//      and nothing is committed after release.
//   2. mult a=0xFFFFFFFE(-2), b=3; start at edge 0 -> busy=1 for cycles 1..5,
//      hi=0xFFFFFFFF, lo=0xFFFFFFFA in cycle 6; multu with the same operands
//      -> hi=0x00000002, lo=0xFFFFFFFA.
//   3. div a=-7(0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1) after
//      10 busy cycles; divu a=7, b=2 -> lo=3, hi=1.
//   4. Prior hi=0x11, lo=0x22; divu b=0 -> busy 10 cycles, then hi=0x11, lo=0x22;
//      div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//   5. Busy-time inputs: during BUSY pulse start (a=1,b=1) and hi_we (wdata=0xDEAD)
//      -> both ignored, original result committed.
//      In IDLE, lo_we with wdata=0x1234 -> lo=0x1234 next cycle.
//      In IDLE, start+hi_we together -> hi takes the product, not wdata.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit for the EX stage of a 5-stage MIPS pipeline.
// Latches op/operands on start, stays busy for a fixed latency selected by the
// operation class, then commits the result into the architectural HI/LO pair.
// The arithmetic is evaluated from the latched operands and only reaches HI/LO
// on the final busy edge, so HI/LO never change before the commit.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    logic [CW-1:0] counter;
    logic [1:0]    op_q;
    logic [31:0]   a_q;
    logic [31:0]   b_q;

    // Result datapath, evaluated from the latched operands
    logic          is_signed;
    logic [63:0]   ext_a;
    logic [63:0]   ext_b;
    logic [63:0]   prod;
    logic [31:0]   abs_a;
    logic [31:0]   abs_b;
    logic [31:0]   quot_u;
    logic [31:0]   rem_u;
    logic [31:0]   quot;
    logic [31:0]   rem;
    logic [31:0]   res_hi;
    logic [31:0]   res_lo;
    logic          res_valid;

    // Compute the product or the quotient/remainder of the latched operands
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        is_signed = ~op_q[0];
        ext_a     = is_signed ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        ext_b     = is_signed ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod      = ext_a * ext_b;

        // Signed division is done on magnitudes, then the signs are restored:
        // quotient truncates toward zero, remainder follows the dividend.
        // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
        abs_a     = (is_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
        abs_b     = (is_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
        quot_u    = '0;
        rem_u     = '0;
        if (b_q != 32'd0) begin
            quot_u = abs_a / abs_b;
            rem_u  = abs_a % abs_b;
        end
        quot      = (is_signed && (a_q[31] ^ b_q[31])) ? (~quot_u + 32'd1) : quot_u;
        rem       = (is_signed && a_q[31]) ? (~rem_u + 32'd1) : rem_u;

        if (op_q[1]) begin
            res_hi    = rem;
            res_lo    = quot;
            // Divide by zero runs the full latency but leaves HI/LO untouched
            res_valid = (b_q != 32'd0);
        end else begin
            res_hi    = prod[63:32];
            res_lo    = prod[31:0];
            res_valid = 1'b1;
        end
    end

    // Control FSM with registered busy and the HI/LO architectural registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            case (state)
                IDLE: begin
                    if (start) begin
                        // start has priority; a simultaneous mthi/mtlo is dropped
                        op_q    <= op;
                        a_q     <= operand_a;
                        b_q     <= operand_b;
                        counter <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        busy    <= 1'b1;
                        state   <= BUSY;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                BUSY: begin
                    // start, hi_we and lo_we are ignored here
                    counter <= counter - CW'(1);
                    if (counter == CW'(1)) begin
                        if (res_valid) begin
                            hi <= res_hi;
                            lo <= res_lo;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
